// File: rtl/ped_signal_ctrl.sv
// Pedestrian WALK / DON'T-WALK controller slaved to the vehicle semaphore lamps.
// Optional build macro PED_RECALL_EN: grant WALK on every red rise without a button press.
module ped_signal_ctrl #(
    parameter int WALK_CYCLES  = 30,
    parameter int FLASH_CYCLES = 16,
    parameter int FLASH_HALF   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ped_btn,
    input  logic       red,
    input  logic       yellow,
    input  logic       green,
    output logic       walk,
    output logic       dont_walk,
    output logic       req_pending,
    output logic [3:0] state_out
);
    localparam int CMAX = (WALK_CYCLES > FLASH_CYCLES) ? WALK_CYCLES : FLASH_CYCLES;
    localparam int CW   = $clog2(CMAX > 2 ? CMAX : 2);
    localparam int BW   = $clog2(FLASH_HALF > 2 ? FLASH_HALF : 2);

    typedef enum logic [3:0] {
        DARK  = 4'b0001,
        STOP  = 4'b0010,
        WALK  = 4'b0100,
        FLASH = 4'b1000
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [BW-1:0] bcnt;
    logic          blink;
    logic          red_q;
    logic          btn_q;
    logic          lamp_ok;
    logic          red_rise;
    logic          btn_rise;
    logic          grant;

    assign lamp_ok  = (red & ~yellow & ~green) | (~red & yellow & ~green) | (~red & ~yellow & green);
    assign red_rise = red & ~red_q;
    assign btn_rise = ped_btn & ~btn_q;
`ifdef PED_RECALL_EN
    assign grant = red_rise;
`else
    assign grant = red_rise & req_pending;
`endif
    assign state_out = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= DARK;
            walk        <= 1'b0;
            dont_walk   <= 1'b0;
            req_pending <= 1'b0;
            cnt         <= '0;
            bcnt        <= '0;
            blink       <= 1'b0;
            red_q       <= 1'b0;
            btn_q       <= 1'b0;
        end else begin
            red_q <= red;
            btn_q <= ped_btn;
            // Semaphore off or showing an illegal combination: blank both lamps.
            if (!lamp_ok) begin
                state       <= DARK;
                walk        <= 1'b0;
                dont_walk   <= 1'b0;
                req_pending <= 1'b0;
                cnt         <= '0;
                bcnt        <= '0;
                blink       <= 1'b0;
            end else begin
                case (state)
                    DARK: begin
                        state     <= STOP;
                        walk      <= 1'b0;
                        dont_walk <= 1'b1;
                    end
                    STOP: begin
                        if (grant) begin
                            state       <= WALK;
                            walk        <= 1'b1;
                            dont_walk   <= 1'b0;
                            cnt         <= CW'(WALK_CYCLES - 1);
                            req_pending <= 1'b0;
                        end else begin
                            walk      <= 1'b0;
                            dont_walk <= 1'b1;
                            if (btn_rise) req_pending <= 1'b1;
                        end
                    end
                    WALK: begin
                        if (!red) begin
                            state     <= STOP;
                            walk      <= 1'b0;
                            dont_walk <= 1'b1;
                            cnt       <= '0;
                        end else if (cnt == '0) begin
                            state     <= FLASH;
                            walk      <= 1'b0;
                            dont_walk <= 1'b1;
                            cnt       <= CW'(FLASH_CYCLES - 1);
                            blink     <= 1'b1;
                            bcnt      <= BW'(FLASH_HALF - 1);
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    FLASH: begin
                        if (!red || cnt == '0) begin
                            state     <= STOP;
                            walk      <= 1'b0;
                            dont_walk <= 1'b1;
                            cnt       <= '0;
                            bcnt      <= '0;
                            blink     <= 1'b0;
                        end else begin
                            cnt <= cnt - 1'b1;
                            // Lamp follows the next blink value so it changes on this edge.
                            if (bcnt == '0) begin
                                blink     <= ~blink;
                                dont_walk <= ~blink;
                                bcnt      <= BW'(FLASH_HALF - 1);
                            end else begin
                                bcnt <= bcnt - 1'b1;
                            end
                        end
                    end
                    default: begin
                        state     <= DARK;
                        walk      <= 1'b0;
                        dont_walk <= 1'b0;
                        cnt       <= '0;
                    end
                endcase
            end
        end
    end
endmodule
